// File: rtl/adder_tb_pkg.sv
// -----------------------------------------------------------------------------
// adder_tb_pkg
// Shared types and constants for the two-bit adder operand sequencer.
//   - seq_state_e : sequencer FSM states (IDLE/DRIVE/CHECK/DONE)
//   - NUM_VECTORS, OPERAND_W, SUM_W : sweep size and adder port widths
//   - IDX_W, ERR_W, CNT_W           : derived counter widths
//   - golden_sum()                  : reference a+b, reusable by benches
// -----------------------------------------------------------------------------
package adder_tb_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int OPERAND_W   = 2;
    localparam int SUM_W       = 3;
    localparam int IDX_W       = 4;
    // One extra bit so a sweep with every vector failing (16) still fits.
    localparam int ERR_W       = 5;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    function automatic logic [SUM_W-1:0] golden_sum(
        input logic [OPERAND_W-1:0] a,
        input logic [OPERAND_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/settle_counter.sv
// -----------------------------------------------------------------------------
// settle_counter
// Counts how long the current operand pair has been held on the adder inputs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : synchronous clear (wins over i_en)
//   i_en       : count enable
//   o_tc       : terminal count, high while the count equals SETTLE_CYCLES-1
// -----------------------------------------------------------------------------
module settle_counter
    import adder_tb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // The count may step one past TC_VAL on the cycle the FSM leaves DRIVE;
    // it is always cleared before the next hold, and with SETTLE_CYCLES<=15
    // that step never overflows the 4-bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/adder_operand_sequencer.sv
// -----------------------------------------------------------------------------
// adder_operand_sequencer
// Sweeps all 16 operand pairs into a 2-bit adder, holds each for SETTLE_CYCLES,
// samples the 3-bit sum and compares it against a+b.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle sweep request (ignored while busy)
//   a_o, b_o       : operands to the adder (registered)
//   s_i            : sum from the adder
//   busy           : sweep in progress
//   chk_valid      : one-cycle compare pulse, qualifies chk_ok/chk_idx
//   chk_ok,chk_idx : compare result and vector index
//   err_count      : mismatches in the current/last sweep
//   first_err_idx  : index of first mismatch (valid when err_count != 0)
//   done, pass     : sweep complete, and complete with no errors
// -----------------------------------------------------------------------------
module adder_operand_sequencer
    import adder_tb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [OPERAND_W-1:0] a_o,
    output logic [OPERAND_W-1:0] b_o,
    input  logic [SUM_W-1:0]     s_i,
    output logic                 busy,
    output logic                 chk_valid,
    output logic                 chk_ok,
    output logic [IDX_W-1:0]     chk_idx,
    output logic [ERR_W-1:0]     err_count,
    output logic [IDX_W-1:0]     first_err_idx,
    output logic                 done,
    output logic                 pass
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    seq_state_e        r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_busy;
    logic              r_chk_valid;
    logic              r_chk_ok;
    logic [IDX_W-1:0]  r_chk_idx;
    logic [ERR_W-1:0]  r_err_count;
    logic [IDX_W-1:0]  r_first_err_idx;
    logic              r_done;
    logic              r_pass;

    logic              w_accept;
    logic              w_cnt_clear;
    logic              w_cnt_en;
    logic              w_settled;
    logic              w_mismatch;
    logic [ERR_W-1:0]  w_err_next;

    // Operands come straight from the index register, so they never glitch.
    assign a_o = r_idx[IDX_W-1 -: OPERAND_W];
    assign b_o = r_idx[OPERAND_W-1:0];

    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch = (s_i != golden_sum(a_o, b_o));
    assign w_err_next = r_err_count + (w_mismatch ? ERR_W'(1) : ERR_W'(0));

    // Clearing in CHECK readies the counter for the next pair; on the final
    // vector it is harmless because DONE does not use the count.
    assign w_cnt_clear = w_accept || (r_state == CHECK);
    assign w_cnt_en    = (r_state == DRIVE);

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_tc    (w_settled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_busy          <= 1'b0;
            r_chk_valid     <= 1'b0;
            r_chk_ok        <= 1'b0;
            r_chk_idx       <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_chk_valid <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state         <= DRIVE;
                        r_idx           <= '0;
                        r_busy          <= 1'b1;
                        r_err_count     <= '0;
                        r_first_err_idx <= '0;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_settled) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_chk_valid <= 1'b1;
                    r_chk_idx   <= r_idx;
                    r_chk_ok    <= !w_mismatch;
                    r_err_count <= w_err_next;
                    if (w_mismatch && (r_err_count == '0)) begin
                        r_first_err_idx <= r_idx;
                    end
                    if (r_idx == LAST_IDX) begin
                        // idx stays at 15 so the operands rest at 3/3.
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_state <= DRIVE;
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign chk_valid     = r_chk_valid;
    assign chk_ok        = r_chk_ok;
    assign chk_idx       = r_chk_idx;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;
    assign done          = r_done;
    assign pass          = r_pass;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adder_operand_sequencer
// Two sequencers (SETTLE_CYCLES=1 and 3) each drive a behavioural adder whose
// sum can be corrupted per vector through a fault mask. The expected sweep
// result is derived from the mask table alone.
// -----------------------------------------------------------------------------
module tb_adder_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rn[2];
    logic       st[2];
    logic [1:0] w_a[2];
    logic [1:0] w_b[2];
    logic [2:0] w_s[2];
    logic       w_busy[2];
    logic       w_cv[2];
    logic       w_ok[2];
    logic [3:0] w_ci[2];
    logic [4:0] w_ec[2];
    logic [3:0] w_fe[2];
    logic       w_done[2];
    logic       w_pass[2];

    // Per-vector XOR applied to the true sum; 0 means the adder is correct.
    logic [2:0] mask[2][16];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 2; g++) begin : g_adder
        assign w_s[g] = 3'(w_a[g] + w_b[g]) ^ mask[g][{w_a[g], w_b[g]}];
    end

    adder_operand_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rn[0]), .start(st[0]),
        .a_o(w_a[0]), .b_o(w_b[0]), .s_i(w_s[0]),
        .busy(w_busy[0]), .chk_valid(w_cv[0]), .chk_ok(w_ok[0]),
        .chk_idx(w_ci[0]), .err_count(w_ec[0]), .first_err_idx(w_fe[0]),
        .done(w_done[0]), .pass(w_pass[0])
    );

    adder_operand_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rn[1]), .start(st[1]),
        .a_o(w_a[1]), .b_o(w_b[1]), .s_i(w_s[1]),
        .busy(w_busy[1]), .chk_valid(w_cv[1]), .chk_ok(w_ok[1]),
        .chk_idx(w_ci[1]), .err_count(w_ec[1]), .first_err_idx(w_fe[1]),
        .done(w_done[1]), .pass(w_pass[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs(input int sel);
        return {10'd0, w_a[sel], w_b[sel], w_busy[sel], w_cv[sel], w_ok[sel],
                w_ci[sel], w_ec[sel], w_fe[sel], w_done[sel], w_pass[sel]};
    endfunction

    // mode: 0 correct, 1 sum stuck at 0, 2 sum LSB inverted, 3 random faults
    task automatic set_masks(input int sel, input int mode);
        for (int v = 0; v < 16; v++) begin
            case (mode)
                0: mask[sel][v] = 3'd0;
                1: mask[sel][v] = 3'((v / 4) + (v % 4));
                2: mask[sel][v] = 3'd1;
                default: mask[sel][v] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            endcase
        end
    endtask

    task automatic sweep(input int sel, input int S, input int pulse_at, input int rst_at);
        int  exp_err = 0;
        int  exp_first = 0;
        int  nv = 0;
        bit  prev_cv = 0;
        bit  fin = 0;
        int  lat = 16 * (S + 1);
        for (int v = 0; v < 16; v++) begin
            if (mask[sel][v] != 3'd0) begin
                if (exp_err == 0) exp_first = v;
                exp_err++;
            end
        end
        @(negedge clk); st[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk); st[sel] = 1'b0;
        chk("start_state", {w_busy[sel], w_done[sel], w_pass[sel], w_ec[sel]}, {3'b100, 5'd0});
        for (int k = 0; k <= lat + 4 && !fin; k++) begin
            if (k == rst_at) begin
                #2 rn[sel] = 1'b0;
                #1 chk("async_rst", outs(sel), 32'd0);
                @(posedge clk); #1;
                chk("rst_hold", outs(sel), 32'd0);
                @(negedge clk); rn[sel] = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("idle_after_rst", outs(sel), 32'd0);
                end
                return;
            end
            st[sel] = (k == pulse_at);
            if (w_cv[sel]) begin
                chk("chk_consec", 32'(prev_cv), 32'd0);
                chk("chk_idx", 32'(w_ci[sel]), 32'(nv));
                chk("chk_time", 32'(k), 32'((nv + 1) * (S + 1)));
                chk("chk_ok", 32'(w_ok[sel]), 32'(mask[sel][nv & 15] == 3'd0));
                nv++;
            end
            prev_cv = w_cv[sel];
            if (w_done[sel]) begin
                chk("done_time", 32'(k), 32'(lat));
                chk("num_chk", 32'(nv), 32'd16);
                chk("err_count", 32'(w_ec[sel]), 32'(exp_err));
                if (exp_err != 0) chk("first_err", 32'(w_fe[sel]), 32'(exp_first));
                chk("pass", 32'(w_pass[sel]), 32'(exp_err == 0));
                chk("done_rest", {w_busy[sel], w_a[sel], w_b[sel]}, 32'b0_11_11);
                fin = 1;
            end else begin
                chk("busy", 32'(w_busy[sel]), 32'd1);
                chk("operands", 32'({w_a[sel], w_b[sel]}), 32'(k / (S + 1)));
                @(negedge clk);
            end
        end
        st[sel] = 1'b0;
        if (!fin) chk("timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_hold", {w_done[sel], w_cv[sel], w_busy[sel]}, 32'b100);
    endtask

    initial begin
        rn[0] = 1'b0; rn[1] = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;
        set_masks(0, 0);
        set_masks(1, 0);
        #1;
        chk("reset0", outs(0), 32'd0);
        chk("reset1", outs(1), 32'd0);
        repeat (2) @(negedge clk);
        rn[0] = 1'b1; rn[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle0", outs(0), 32'd0);

        set_masks(0, 0); sweep(0, 1, -1, -1);
        set_masks(0, 1); sweep(0, 1, -1, -1);
        set_masks(0, 2); sweep(0, 1, -1, -1);
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            set_masks(0, 3); sweep(0, 1, -1, -1);
        end

        set_masks(1, 0); sweep(1, 3, -1, -1);
        set_masks(1, 3); sweep(1, 3, -1, -1);

        // start during a sweep is ignored; start in DONE restarts at once
        set_masks(0, 0); sweep(0, 1, 9, -1);
        set_masks(0, 3); sweep(0, 1, -1, -1);

        // reset mid-sweep, then a fresh sweep
        set_masks(0, 0); sweep(0, 1, -1, 10);
        set_masks(0, 3); sweep(0, 1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
